// File: rtl/wb_pipe_reg_pkg.sv
// Shared types and constants for the MEM->WB pipeline register.
// The package is mips_pipe_pkg and is imported by wb_pipe_stage and wb_pipe_reg.
package mips_pipe_pkg;

  localparam int WB_DATA_W  = 32;
  localparam int WB_REG_AW  = 5;
  localparam int STAGES_MAX = 4;

  // Zero register address bit; replicate it to the address width at the point of use.
  localparam logic REG_ZERO = 1'b0;

  // Writeback payload at the default widths.
  // wb_pipe_reg builds a field-identical copy at its configured widths.
  typedef struct packed {
    logic                 reg_write;
    logic                 mem_to_reg;
    logic [WB_DATA_W-1:0] read_data;
    logic [WB_DATA_W-1:0] alu_out;
    logic [WB_REG_AW-1:0] write_reg;
  } wb_payload_t;

endpackage

// File: rtl/wb_pipe_reg_if.sv
// MEM->WB bus: handshake, payload in, writeback results out.
// The counter signals exist only when WB_PERF_CNT_EN is defined.
interface wb_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic              reg_write_i;
  logic              mem_to_reg_i;
  logic [DATA_W-1:0] read_data_i;
  logic [DATA_W-1:0] alu_out_i;
  logic [REG_AW-1:0] write_reg_i;
  logic              valid_o;
  logic              reg_write_o;
  logic              mem_to_reg_o;
  logic [DATA_W-1:0] read_data_o;
  logic [DATA_W-1:0] alu_out_o;
  logic [REG_AW-1:0] write_reg_o;
  logic [DATA_W-1:0] result_o;
  logic              reg_write_hz_o;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("wb_pipe_reg_if: CNT_W must be >= 1");
  end

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, reg_write_i, mem_to_reg_i,
           read_data_i, alu_out_i, write_reg_i,
    input  valid_o, reg_write_o, mem_to_reg_o, read_data_o, alu_out_o,
           write_reg_o, result_o, reg_write_hz_o, stall_cnt_o, bubble_cnt_o
  );
  modport slave (
    input  stall_i, flush_i, valid_i, reg_write_i, mem_to_reg_i,
           read_data_i, alu_out_i, write_reg_i,
    output valid_o, reg_write_o, mem_to_reg_o, read_data_o, alu_out_o,
           write_reg_o, result_o, reg_write_hz_o, stall_cnt_o, bubble_cnt_o
  );
`else
  modport master (
    output stall_i, flush_i, valid_i, reg_write_i, mem_to_reg_i,
           read_data_i, alu_out_i, write_reg_i,
    input  valid_o, reg_write_o, mem_to_reg_o, read_data_o, alu_out_o,
           write_reg_o, result_o, reg_write_hz_o
  );
  modport slave (
    input  stall_i, flush_i, valid_i, reg_write_i, mem_to_reg_i,
           read_data_i, alu_out_i, write_reg_i,
    output valid_o, reg_write_o, mem_to_reg_o, read_data_o, alu_out_o,
           write_reg_o, result_o, reg_write_hz_o
  );
`endif

endinterface

// File: rtl/wb_pipe_reg_stage.sv
// One MEM->WB stage: a valid bit plus payload, with hold, kill and load.
// A kill clears only the valid bit, so a stalled stage keeps its payload.
module wb_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter type PL_T = wb_payload_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold_i,
  input  logic kill_i,
  input  logic vld_d,
  input  PL_T  pl_d,
  output logic vld_q,
  output PL_T  pl_q
);

  // Stage register: a kill has priority over a hold, which has priority over a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      pl_q  <= '0;
    end else if (kill_i) begin
      vld_q <= 1'b0;
    end else if (!hold_i) begin
      vld_q <= vld_d;
      pl_q  <= pl_d;
    end
  end

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register: a chain of STAGES stages with stall, flush,
// suppression of writes to $0, and the writeback result mux.
// The optional stall/bubble counters are enabled by defining WB_PERF_CNT_EN.
module wb_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_pipe_reg_if.slave  bus
);

  // Same fields as wb_payload_t, sized to this instance's widths.
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_out;
    logic [REG_AW-1:0] write_reg;
  } pl_t;

  localparam logic [REG_AW-1:0] WR_ZERO = {REG_AW{REG_ZERO}};

  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("wb_pipe_reg: STAGES must be 1..%0d", STAGES_MAX);
  end

  logic [STAGES:0] vld_pipe;
  pl_t             pl_pipe [STAGES:0];
  pl_t             fin;

  // Stage-0 input. A flushed or invalid slot enters as a zero bubble.
  // RegWrite is gated here so that bubbles and writes to $0 never carry it.
  assign vld_pipe[0] = bus.valid_i & ~bus.flush_i;
  assign pl_pipe[0]  = vld_pipe[0] ?
    '{reg_write:  bus.reg_write_i & (bus.write_reg_i != WR_ZERO),
      mem_to_reg: bus.mem_to_reg_i,
      read_data:  bus.read_data_i,
      alu_out:    bus.alu_out_i,
      write_reg:  bus.write_reg_i} : '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    wb_pipe_stage #(.PL_T(pl_t)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold_i (bus.stall_i),
      .kill_i ((k == 0) && bus.stall_i && bus.flush_i),
      .vld_d  (vld_pipe[k]),
      .pl_d   (pl_pipe[k]),
      .vld_q  (vld_pipe[k+1]),
      .pl_q   (pl_pipe[k+1])
    );
  end

  assign fin                = pl_pipe[STAGES];
  assign bus.valid_o        = vld_pipe[STAGES];
  // Gate with valid once more, so a killed stage can never drive a write.
  assign bus.reg_write_o    = fin.reg_write & vld_pipe[STAGES];
  assign bus.reg_write_hz_o = fin.reg_write & vld_pipe[STAGES];
  assign bus.mem_to_reg_o   = fin.mem_to_reg;
  assign bus.read_data_o    = fin.read_data;
  assign bus.alu_out_o      = fin.alu_out;
  assign bus.write_reg_o    = fin.write_reg;
  assign bus.result_o       = fin.mem_to_reg ? fin.read_data : fin.alu_out;

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  // Saturating counters for stall edges and for edges with an unstalled empty final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bus.stall_i && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!vld_pipe[STAGES] && !bus.stall_i && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt_o  = stall_cnt;
  assign bus.bubble_cnt_o = bubble_cnt;
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("wb_pipe_reg: CNT_W must be >= 1");
  end
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg.
// Three instances (STAGES = 1, 2 and 3) are driven by one stimulus stream.
// The counter checks take part only when WB_PERF_CNT_EN is defined.
module tb_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, valid = 1'b0, rw = 1'b0, m2r = 1'b0;
  logic [31:0] rd = '0, alu = '0;
  logic [4:0]  wr = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wb_pipe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  b1 ();
  wb_pipe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) b2 ();
  wb_pipe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) b3 ();

  assign b1.stall_i = stall;  assign b2.stall_i = stall;  assign b3.stall_i = stall;
  assign b1.flush_i = flush;  assign b2.flush_i = flush;  assign b3.flush_i = flush;
  assign b1.valid_i = valid;  assign b2.valid_i = valid;  assign b3.valid_i = valid;
  assign b1.reg_write_i = rw; assign b2.reg_write_i = rw; assign b3.reg_write_i = rw;
  assign b1.mem_to_reg_i = m2r; assign b2.mem_to_reg_i = m2r; assign b3.mem_to_reg_i = m2r;
  assign b1.read_data_i = rd; assign b2.read_data_i = rd; assign b3.read_data_i = rd;
  assign b1.alu_out_i = alu;  assign b2.alu_out_i = alu;  assign b3.alu_out_i = alu;
  assign b1.write_reg_i = wr; assign b2.write_reg_i = wr; assign b3.write_reg_i = wr;

  wb_pipe_reg #(.DATA_W(32), .REG_AW(5), .STAGES(1), .CNT_W(2))  d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  wb_pipe_reg #(.DATA_W(32), .REG_AW(5), .STAGES(2), .CNT_W(16)) d2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  wb_pipe_reg #(.DATA_W(32), .REG_AW(5), .STAGES(3), .CNT_W(16)) d3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic m, input logic [31:0] d,
                       input logic [31:0] a, input logic [4:0] w);
    valid = 1'b1; rw = r; m2r = m; rd = d; alu = a; wr = w;
  endtask

  task automatic idle();
    valid = 1'b0; rw = 1'b0; m2r = 1'b0; rd = '0; alu = '0; wr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst d1 valid", b1.valid_o, 1'b0);
    check("rst d3 result", b3.result_o, 32'h0);
    check("rst d3 rw", b3.reg_write_o, 1'b0);
`ifdef WB_PERF_CNT_EN
    check("rst d1 stall_cnt", b1.stall_cnt_o, 2'd0);
    check("rst d3 bubble_cnt", b3.bubble_cnt_o, 16'd0);
`endif
    #4 rst_n = 1'b1;

    // Single stage, then three instructions streamed through all depths
    drive(1'b1, 1'b0, 32'hdead, 32'h1234, 5'd8);
    step();
    check("e1 d1 valid", b1.valid_o, 1'b1);
    check("e1 d1 result", b1.result_o, 32'h1234);
    check("e1 d1 rw", b1.reg_write_o, 1'b1);
    check("e1 d1 hz", b1.reg_write_hz_o, 1'b1);
    check("e1 d1 wr", b1.write_reg_o, 5'd8);
    check("e1 d3 valid", b3.valid_o, 1'b0);
    drive(1'b1, 1'b1, 32'h5555, 32'h1, 5'd3);
    step();
    check("e2 d1 result", b1.result_o, 32'h5555);
    check("e2 d2 result", b2.result_o, 32'h1234);
    check("e2 d2 valid", b2.valid_o, 1'b1);
    check("e2 d3 valid", b3.valid_o, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd0);
    step();
    check("e3 d1 valid", b1.valid_o, 1'b1);
    check("e3 d1 rw0", b1.reg_write_o, 1'b0);
    check("e3 d1 hz0", b1.reg_write_hz_o, 1'b0);
    check("e3 d1 result", b1.result_o, 32'h77);
    check("e3 d3 result", b3.result_o, 32'h1234);
    check("e3 d3 rw", b3.reg_write_o, 1'b1);
    check("e3 d3 wr", b3.write_reg_o, 5'd8);
    idle();
    step();
    check("e4 d1 valid", b1.valid_o, 1'b0);
    check("e4 d1 result", b1.result_o, 32'h0);
    check("e4 d3 result", b3.result_o, 32'h5555);
    check("e4 d3 m2r", b3.mem_to_reg_o, 1'b1);
    check("e4 d3 wr", b3.write_reg_o, 5'd3);
    step();
    check("e5 d3 valid", b3.valid_o, 1'b1);
    check("e5 d3 result", b3.result_o, 32'h77);
    check("e5 d3 rw0", b3.reg_write_o, 1'b0);
    check("e5 d3 hz0", b3.reg_write_hz_o, 1'b0);
    step();
    check("e6 d3 valid", b3.valid_o, 1'b0);
    check("e6 d3 result", b3.result_o, 32'h0);

    // Five-cycle stall in mid-stream
    drive(1'b1, 1'b0, 32'h0, 32'h10, 5'd1); step();
    drive(1'b1, 1'b0, 32'h0, 32'h20, 5'd2); step();
    drive(1'b1, 1'b0, 32'h0, 32'h30, 5'd3); step();
    check("pre-stall d3 result", b3.result_o, 32'h10);
    check("pre-stall d2 result", b2.result_o, 32'h20);
    stall = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'h40, 5'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall%0d d3 result", i), b3.result_o, 32'h10);
      check($sformatf("stall%0d d3 valid", i), b3.valid_o, 1'b1);
    end
    stall = 1'b0;
    step();
    check("post d3 E", b3.result_o, 32'h20);
    check("post d2 F", b2.result_o, 32'h30);
    idle();
    step();
    check("post d3 F", b3.result_o, 32'h30);
    check("post d2 G", b2.result_o, 32'h40);
    step();
    check("post d3 G", b3.result_o, 32'h40);
    check("post d3 wr", b3.write_reg_o, 5'd4);
    step();
    check("post d3 drained", b3.valid_o, 1'b0);
`ifdef WB_PERF_CNT_EN
    check("d3 stall_cnt", b3.stall_cnt_o, 16'd5);
    check("d2 stall_cnt", b2.stall_cnt_o, 16'd5);
    check("d1 stall_cnt sat", b1.stall_cnt_o, 2'd3);
    check("d1 bubble_cnt sat", b1.bubble_cnt_o, 2'd3);
`endif

    // Flush together with stall, then a flush on its own
    drive(1'b1, 1'b0, 32'h0, 32'h100, 5'd5); step();
    drive(1'b1, 1'b0, 32'h0, 32'h200, 5'd6); step();
    check("fs d2 H", b2.result_o, 32'h100);
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'h300, 5'd9);
    step();
    check("fs d2 held valid", b2.valid_o, 1'b1);
    check("fs d2 held result", b2.result_o, 32'h100);
    check("fs d2 held rw", b2.reg_write_o, 1'b1);
    check("fs d2 held wr", b2.write_reg_o, 5'd5);
    check("fs d1 killed", b1.valid_o, 1'b0);
    stall = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h400, 5'd10);
    step();
    check("fs d2 killed valid", b2.valid_o, 1'b0);
    check("fs d2 killed rw", b2.reg_write_o, 1'b0);
    check("fs d2 killed hz", b2.reg_write_hz_o, 1'b0);
    check("fl d1 valid", b1.valid_o, 1'b0);
    check("fl d1 result", b1.result_o, 32'h0);
    check("fl d1 rw", b1.reg_write_o, 1'b0);
    flush = 1'b0;
    idle();
    step();
    check("fl d2 bubble valid", b2.valid_o, 1'b0);
    check("fl d2 bubble result", b2.result_o, 32'h0);

    // Asynchronous reset while stalled with a full pipe
    drive(1'b1, 1'b0, 32'h0, 32'h3, 5'd7);
    step(); step(); step();
    check("full d3 valid", b3.valid_o, 1'b1);
    check("full d3 result", b3.result_o, 32'h3);
    stall = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("arst d3 valid", b3.valid_o, 1'b0);
    check("arst d3 result", b3.result_o, 32'h0);
    check("arst d3 rw", b3.reg_write_o, 1'b0);
    check("arst d3 hz", b3.reg_write_hz_o, 1'b0);
    check("arst d3 wr", b3.write_reg_o, 5'd0);
    check("arst d1 valid", b1.valid_o, 1'b0);
`ifdef WB_PERF_CNT_EN
    check("arst d3 stall_cnt", b3.stall_cnt_o, 16'd0);
    check("arst d1 bubble_cnt", b1.bubble_cnt_o, 2'd0);
`endif
    step();
    check("arst held d3 valid", b3.valid_o, 1'b0);
    stall = 1'b0;
    idle();
    #2 rst_n = 1'b1;
    step();
    check("rel d3 valid", b3.valid_o, 1'b0);
    check("rel d3 result", b3.result_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
